analog_conv_sequencer: RTL and testbench

//  Schedules ADC conversions for the amdc_analog peripheral. Qualifies PWM carrier

---
 rtl/analog_conv_sequencer.sv | 117 +++++++++++
 tb/tb_analog_conv_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_conv_sequencer.sv
// ADC conversion sequencer: qualifies and decimates PWM/software triggers, runs one
// start/done handshake per accepted trigger, and latches a coherent channel snapshot.
module analog_conv_sequencer #(
   parameter int NUM_CHANNELS   = 8,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                               ACLK,
   input  logic                               ARESETN,
   input  logic                               enable,
   input  logic [1:0]                         trig_sel,
   input  logic                               carrier_high,
   input  logic                               carrier_low,
   input  logic                               sw_trig,
   input  logic [7:0]                         trig_div,
   output logic                               adc_start,
   input  logic                               adc_done,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] adc_data,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] result,
   output logic                               result_valid,
   output logic                               seq_busy,
   output logic [15:0]                        overrun_cnt,
   output logic                               timeout_err,
   input  logic                               err_clr
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_LATCH
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [7:0]      dec_cnt;
   logic [7:0]      div_lim;
   logic [TW-1:0]   tmo_cnt;
   logic            sel_hi;
   logic            sel_lo;
   logic            evt;
   logic            fire;
   logic            overrun;
   logic            tmo_hit;

   // Coincident trigger sources collapse into a single event
   always_comb begin
      sel_hi  = (trig_sel == 2'b00) || (trig_sel == 2'b10);
      sel_lo  = (trig_sel == 2'b01) || (trig_sel == 2'b10);
      evt     = enable & (sw_trig | (carrier_high & sel_hi) | (carrier_low & sel_lo));
      div_lim = (trig_div == 8'd0) ? 8'd0 : trig_div - 8'd1;
      // >= rather than == so that lowering trig_div below the current count fires at once
      fire    = evt && (dec_cnt >= div_lim);
      overrun = fire && (state != S_IDLE);
   end

   always_comb begin
      next_state = state;
      tmo_hit    = 1'b0;
      case (state)
         S_IDLE:  if (fire) next_state = S_START;
         S_START: next_state = S_WAIT;
         S_WAIT: begin
            if (adc_done) begin
               next_state = S_LATCH;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit    = 1'b1;
               next_state = S_IDLE;
            end
         end
         S_LATCH: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state       <= S_IDLE;
         dec_cnt     <= '0;
         tmo_cnt     <= '0;
         result      <= '0;
         overrun_cnt <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= next_state;

         if (!enable)  dec_cnt <= '0;
         else if (evt) dec_cnt <= fire ? 8'd0 : dec_cnt + 8'd1;

         if (state == S_START)     tmo_cnt <= '0;
         else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

         if (state == S_WAIT && adc_done) result <= adc_data;

         // A new overrun beats a simultaneous clear
         if (overrun) begin
            if (err_clr)                     overrun_cnt <= 16'd1;
            else if (overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
         end else if (err_clr) begin
            overrun_cnt <= '0;
         end

         if (tmo_hit)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

   always_comb begin
      adc_start    = (state == S_START);
      result_valid = (state == S_LATCH);
      seq_busy     = (state != S_IDLE);
   end

endmodule

// File: tb/tb_analog_conv_sequencer.sv
// Directed bench for analog_conv_sequencer; expected snapshots are queued by the
// stimulus and checked by an independent monitor on result_valid.
module tb_analog_conv_sequencer;

   localparam int NCH = 8;
   localparam int DW  = 16;
   localparam int RW  = NCH * DW;
   localparam int TMO = 16;

   logic          ACLK;
   logic          ARESETN;
   logic          enable;
   logic [1:0]    trig_sel;
   logic          carrier_high;
   logic          carrier_low;
   logic          sw_trig;
   logic [7:0]    trig_div;
   logic          adc_start;
   logic          adc_done;
   logic [RW-1:0] adc_data;
   logic [RW-1:0] result;
   logic          result_valid;
   logic          seq_busy;
   logic [15:0]   overrun_cnt;
   logic          timeout_err;
   logic          err_clr;

   analog_conv_sequencer #(
      .NUM_CHANNELS   (NCH),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .enable       (enable),
      .trig_sel     (trig_sel),
      .carrier_high (carrier_high),
      .carrier_low  (carrier_low),
      .sw_trig      (sw_trig),
      .trig_div     (trig_div),
      .adc_start    (adc_start),
      .adc_done     (adc_done),
      .adc_data     (adc_data),
      .result       (result),
      .result_valid (result_valid),
      .seq_busy     (seq_busy),
      .overrun_cnt  (overrun_cnt),
      .timeout_err  (timeout_err),
      .err_clr      (err_clr)
   );

   int            n_cmp = 0;
   int            n_err = 0;
   int            n_start = 0;
   int            n_rv = 0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] mon_exp;
   logic [RW-1:0] last_res;

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Monitor: every result_valid must match the oldest queued expectation
   always @(negedge ACLK) begin
      if (adc_start) n_start++;
      if (result_valid) begin
         n_rv++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result_valid: result=%0h, required no result_valid", result);
         end else begin
            mon_exp = exp_q.pop_front();
            if (result !== mon_exp) begin
               n_err++;
               $display("FAIL result: got %0h required %0h", result, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic sample();
      @(negedge ACLK);
   endtask

   // 0 = carrier_high, 1 = carrier_low, 2 = sw_trig
   task automatic pulse(input int which);
      if (which == 0)      carrier_high = 1'b1;
      else if (which == 1) carrier_low  = 1'b1;
      else                 sw_trig      = 1'b1;
      tick();
      carrier_high = 1'b0;
      carrier_low  = 1'b0;
      sw_trig      = 1'b0;
   endtask

   task automatic convert(input logic [RW-1:0] d);
      adc_done = 1'b1;
      adc_data = d;
      exp_q.push_back(d);
      last_res = d;
      tick();
      adc_done = 1'b0;
      adc_data = '0;
   endtask

   function automatic logic [RW-1:0] mk(input logic [15:0] base);
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < NCH; i++) r[i*DW +: DW] = base + 16'(i);
      return r;
   endfunction

   int s0;
   int ov0;
   int rv0;

   initial begin
      ARESETN = 1'b0; enable = 1'b0; trig_sel = 2'b00; trig_div = 8'd1;
      carrier_high = 1'b0; carrier_low = 1'b0; sw_trig = 1'b0;
      adc_done = 1'b0; adc_data = '0; err_clr = 1'b0; last_res = '0;

      // T1: activity during reset must not leak out
      enable = 1'b1; adc_done = 1'b1; adc_data = '1; carrier_high = 1'b1; sw_trig = 1'b1;
      repeat (4) tick();
      sample();
      chk("rst_adc_start", adc_start, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_seq_busy", seq_busy, 0);
      chk("rst_result", result, 0);
      chk("rst_overrun_cnt", overrun_cnt, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_start_count", n_start, 0);
      tick();
      enable = 1'b0; adc_done = 1'b0; adc_data = '0; carrier_high = 1'b0; sw_trig = 1'b0;
      ARESETN = 1'b1;
      tick();

      // T2: basic peak trigger, done 5 cycles after the fire cycle
      enable = 1'b1; trig_sel = 2'b00; trig_div = 8'd1;
      pulse(0);
      sample();
      chk("t2_start_n1", adc_start, 1);
      chk("t2_busy_n1", seq_busy, 1);
      tick();
      sample();
      chk("t2_start_n2", adc_start, 0);
      repeat (3) tick();
      chk("t2_no_rv_before_done", n_rv, 0);
      convert(mk(16'h0001));
      sample();
      chk("t2_rv_n6", result_valid, 1);
      tick();
      sample();
      chk("t2_rv_n7", result_valid, 0);
      chk("t2_idle_n7", seq_busy, 0);
      chk("t2_result_held", result, mk(16'h0001));

      // T3: decimation by 3 with alternating peak/valley events
      trig_sel = 2'b10; trig_div = 8'd3;
      s0 = n_start;
      for (int i = 0; i < 6; i++) begin
         pulse(i % 2);
         if (i == 2 || i == 5) begin
            tick();
            convert(mk(16'h0100 * 16'(i + 1)));
            tick();
         end
      end
      chk("t3_div3_starts", n_start - s0, 2);
      chk("t3_no_overrun", overrun_cnt, 0);

      // Lowering trig_div below the current count fires on the next event
      s0 = n_start; trig_div = 8'd4;
      pulse(0); pulse(1); pulse(0);
      tick();
      chk("t3_div4_no_fire", n_start - s0, 0);
      trig_div = 8'd2;
      pulse(1);
      tick();
      convert(mk(16'h0A00));
      tick();
      chk("t3_div_change_fires", n_start - s0, 1);

      // trig_div = 0 behaves as 1
      trig_sel = 2'b00; trig_div = 8'd0;
      s0 = n_start;
      for (int i = 0; i < 2; i++) begin
         pulse(0);
         tick();
         convert(mk(16'h0B00 + 16'(i * 16)));
         tick();
      end
      chk("t3_div0_starts", n_start - s0, 2);

      // Software-only selection ignores carrier events
      trig_sel = 2'b11;
      s0 = n_start;
      pulse(0); pulse(1);
      tick();
      chk("t3_sw_only_ignores_carrier", n_start - s0, 0);
      pulse(2);
      tick();
      convert(mk(16'h0C00));
      tick();
      chk("t3_sw_trig_starts", n_start - s0, 1);

      // T4: three fires before done are overruns
      trig_sel = 2'b00; trig_div = 8'd1;
      pulse(0); pulse(0); pulse(0); pulse(0);
      convert(mk(16'h0D00));
      tick();
      sample();
      chk("t4_overrun3", overrun_cnt, 3);
      tick();
      pulse(0);
      tick();
      convert(mk(16'h0E00));
      pulse(0);
      sample();
      chk("t4_overrun_in_latch", overrun_cnt, 4);
      chk("t4_latch_fire_not_accepted", seq_busy, 0);
      tick();
      pulse(0);
      carrier_high = 1'b1; err_clr = 1'b1;
      tick();
      carrier_high = 1'b0; err_clr = 1'b0;
      sample();
      chk("t4_clr_vs_overrun", overrun_cnt, 1);
      convert(mk(16'h0F00));
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      sample();
      chk("t4_err_clr", overrun_cnt, 0);

      // T5: withheld done times out, result untouched, late done ignored
      tick();
      pulse(2);
      repeat (TMO - 2) tick();
      sample();
      chk("t5_no_timeout_early", timeout_err, 0);
      chk("t5_busy_waiting", seq_busy, 1);
      repeat (3) tick();
      sample();
      chk("t5_timeout_err", timeout_err, 1);
      chk("t5_idle_after_timeout", seq_busy, 0);
      chk("t5_result_unchanged", result, last_res);
      tick();
      adc_done = 1'b1; adc_data = mk(16'hDE00);
      tick();
      adc_done = 1'b0; adc_data = '0;
      tick();
      sample();
      chk("t5_late_done_ignored", result, last_res);
      tick();
      pulse(2);
      tick();
      convert(mk(16'h1100));
      tick();
      sample();
      chk("t5_next_trigger_result", result, mk(16'h1100));
      chk("t5_timeout_sticky", timeout_err, 1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      sample();
      chk("t5_timeout_clr", timeout_err, 0);
      tick();
      err_clr = 1'b1;
      pulse(2);
      repeat (TMO + 1) tick();
      sample();
      err_clr = 1'b0;
      chk("t5_timeout_beats_clr", timeout_err, 1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // T6: dropping enable mid-conversion lets it finish, then blocks triggers
      s0 = n_start; ov0 = int'(overrun_cnt);
      pulse(0);
      tick();
      enable = 1'b0;
      pulse(0); pulse(2);
      convert(mk(16'h1200));
      tick();
      chk("t6_completes_after_disable", n_start - s0, 1);
      chk("t6_no_overrun_disabled", int'(overrun_cnt), ov0);
      pulse(0); pulse(2);
      tick();
      chk("t6_disabled_no_start", n_start - s0, 1);
      chk("t6_disabled_idle", seq_busy, 0);

      // Reset during WAIT aborts without result_valid
      enable = 1'b1;
      rv0 = n_rv;
      pulse(0);
      tick();
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      sample();
      chk("t6_reset_idle", seq_busy, 0);
      chk("t6_reset_result", result, 0);
      tick();
      adc_done = 1'b1; adc_data = mk(16'h1300);
      tick();
      adc_done = 1'b0; adc_data = '0;
      repeat (2) tick();
      chk("t6_no_rv_after_reset", n_rv, rv0);
      chk("t6_result_still_zero", result, 0);

      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
